// File: rtl/pc_cp0_unit_if.sv
`default_nettype none
// ============================================================================
// pc_cp0_unit_if : MTC0/MFC0 access bus between the datapath and the CP0 unit
// Revision 1.0
// ============================================================================
interface pc_cp0_unit_if;
   logic        CP0_WE;
   logic [4:0]  CP0_Addr;
   logic [31:0] CP0_WData;
   logic [31:0] CP0_RData;

   modport master (
      output CP0_WE,
      output CP0_Addr,
      output CP0_WData,
      input  CP0_RData
   );

   modport slave (
      input  CP0_WE,
      input  CP0_Addr,
      input  CP0_WData,
      output CP0_RData
   );
endinterface
`default_nettype wire

// File: rtl/pc_cp0_unit.sv
`default_nettype none
// ============================================================================
// pc_cp0_unit : program counter plus CP0 Status/Cause/EPC/PrID and interrupts
// Revision 1.0
// ============================================================================
module pc_cp0_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] PRID     = 32'h00000001
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic [31:0] PC_D,
   input  wire logic        PCWrite,
   input  wire logic        PCWriteCond,
   input  wire logic        Zero,
   input  wire logic        ExcEnter,
   input  wire logic [4:0]  ExcCode,
   input  wire logic        ERET,
   input  wire logic [5:0]  IntReq,
   pc_cp0_unit_if.slave     cp0,
   output logic [31:0]      PC_Q,
   output logic [31:0]      EPC_Q,
   output logic [31:0]      Status_Q,
   output logic [31:0]      Cause_Q,
   output logic             IntPending
);

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;
   localparam logic [4:0] ADDR_PRID   = 5'd15;

   logic [31:0] pc;
   logic [31:0] epc;
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic [5:0]  int_sync;
   logic [5:0]  ip;
   logic [4:0]  exc_code;

   logic        pc_we;
   logic [31:0] pc_minus4;
   logic [31:0] exc_epc;
   logic        mtc0_status;
   logic        mtc0_epc;

   assign pc_we       = PCWrite | (PCWriteCond & Zero);
   assign pc_minus4   = pc - 32'd4;
   assign exc_epc     = (ExcCode == 5'd0) ? pc : pc_minus4;
   assign mtc0_status = cp0.CP0_WE && (cp0.CP0_Addr == ADDR_STATUS);
   assign mtc0_epc    = cp0.CP0_WE && (cp0.CP0_Addr == ADDR_EPC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (pc_we) begin
         pc <= PC_D;
      end
   end

   // ip is the second synchronizer stage, giving two-edge latency from IntReq
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_sync <= 6'd0;
         ip       <= 6'd0;
      end else begin
         int_sync <= IntReq;
         ip       <= int_sync;
      end
   end

   // ExcEnter beats ERET beats MTC0; a losing MTC0 is dropped completely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc      <= 32'd0;
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         exc_code <= 5'd0;
      end else if (ExcEnter) begin
         exc_code <= ExcCode;
         exl      <= 1'b1;
         epc      <= {exc_epc[31:2], 2'b00};
      end else if (ERET) begin
         exl <= 1'b0;
      end else if (mtc0_status) begin
         im  <= cp0.CP0_WData[15:10];
         exl <= cp0.CP0_WData[1];
         ie  <= cp0.CP0_WData[0];
      end else if (mtc0_epc) begin
         epc <= {cp0.CP0_WData[31:2], 2'b00};
      end
   end

   always_comb begin
      Status_Q        = 32'd0;
      Status_Q[15:10] = im;
      Status_Q[1]     = exl;
      Status_Q[0]     = ie;
      Cause_Q         = 32'd0;
      Cause_Q[15:10]  = ip;
      Cause_Q[6:2]    = exc_code;
   end

   always_comb begin
      case (cp0.CP0_Addr)
         ADDR_STATUS: cp0.CP0_RData = Status_Q;
         ADDR_CAUSE:  cp0.CP0_RData = Cause_Q;
         ADDR_EPC:    cp0.CP0_RData = epc;
         ADDR_PRID:   cp0.CP0_RData = PRID;
         default:     cp0.CP0_RData = 32'd0;
      endcase
   end

   assign PC_Q       = pc;
   assign EPC_Q      = epc;
   assign IntPending = ie & ~exl & (|(ip & im));

endmodule
`default_nettype wire

// File: tb/tb_pc_cp0_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_cp0_unit : scoreboard bench for pc_cp0_unit
// Revision 1.0
// ============================================================================
module tb_pc_cp0_unit;

   localparam logic [31:0] C_PRID = 32'h00000001;

   localparam int SEL_PC     = 0;
   localparam int SEL_EPC    = 1;
   localparam int SEL_STATUS = 2;
   localparam int SEL_CAUSE  = 3;
   localparam int SEL_INT    = 4;
   localparam int SEL_RDATA  = 5;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_entry_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] PC_D;
   logic        PCWrite;
   logic        PCWriteCond;
   logic        Zero;
   logic        ExcEnter;
   logic [4:0]  ExcCode;
   logic        ERET;
   logic [5:0]  IntReq;
   logic [31:0] PC_Q;
   logic [31:0] EPC_Q;
   logic [31:0] Status_Q;
   logic [31:0] Cause_Q;
   logic        IntPending;

   pc_cp0_unit_if cp0 ();

   pc_cp0_unit #(
      .RESET_PC (32'h00000000),
      .PRID     (C_PRID)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PC_D        (PC_D),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .Zero        (Zero),
      .ExcEnter    (ExcEnter),
      .ExcCode     (ExcCode),
      .ERET        (ERET),
      .IntReq      (IntReq),
      .cp0         (cp0.slave),
      .PC_Q        (PC_Q),
      .EPC_Q       (EPC_Q),
      .Status_Q    (Status_Q),
      .Cause_Q     (Cause_Q),
      .IntPending  (IntPending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        n_compared = 0;
   int        n_mismatch = 0;
   sb_entry_t sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatch++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_PC:     return PC_Q;
         SEL_EPC:    return EPC_Q;
         SEL_STATUS: return Status_Q;
         SEL_CAUSE:  return Cause_Q;
         SEL_INT:    return {31'd0, IntPending};
         default:    return cp0.CP0_RData;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
      sb_entry_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      sb_entry_t e;
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      cp0.CP0_WE    = 1'b1;
      cp0.CP0_Addr  = addr;
      cp0.CP0_WData = data;
   endtask

   initial begin
      rst_n = 1'b0;
      PC_D = 32'h12345678;
      PCWrite = 1'b1;
      PCWriteCond = 1'b0;
      Zero = 1'b0;
      ExcEnter = 1'b0;
      ExcCode = 5'd0;
      ERET = 1'b0;
      IntReq = 6'd0;
      cp0.CP0_WE = 1'b0;
      cp0.CP0_Addr = 5'd12;
      cp0.CP0_WData = 32'd0;

      // reset holds despite PCWrite
      tick();
      tick();
      expect_val("rst_pc", SEL_PC, 32'h0);
      expect_val("rst_epc", SEL_EPC, 32'h0);
      expect_val("rst_status", SEL_STATUS, 32'h0);
      expect_val("rst_cause", SEL_CAUSE, 32'h0);
      expect_val("rst_intpend", SEL_INT, 32'h0);
      expect_val("rst_rdata", SEL_RDATA, 32'h0);
      drain();
      rst_n = 1'b1;
      tick();
      expect_val("pc_after_rst", SEL_PC, 32'h12345678);
      drain();

      // conditional write
      PCWrite = 1'b0;
      PCWriteCond = 1'b1;
      Zero = 1'b0;
      PC_D = 32'h40;
      tick();
      expect_val("cond_zero0", SEL_PC, 32'h12345678);
      drain();
      Zero = 1'b1;
      tick();
      expect_val("cond_zero1", SEL_PC, 32'h40);
      drain();

      // syscall entry
      PCWriteCond = 1'b0;
      Zero = 1'b0;
      PCWrite = 1'b1;
      PC_D = 32'h104;
      tick();
      ExcEnter = 1'b1;
      ExcCode = 5'd8;
      PC_D = 32'h180;
      tick();
      expect_val("sys_epc", SEL_EPC, 32'h100);
      expect_val("sys_cause", SEL_CAUSE, 32'h20);
      expect_val("sys_status", SEL_STATUS, 32'h2);
      expect_val("sys_pc", SEL_PC, 32'h180);
      drain();
      ExcEnter = 1'b0;
      PCWrite = 1'b0;
      ERET = 1'b1;
      tick();
      ERET = 1'b0;
      expect_val("eret_status", SEL_STATUS, 32'h0);
      drain();

      // interrupt path; read during write returns old Status
      mtc0(5'd12, 32'h0000FC01);
      expect_val("rd_during_wr", SEL_RDATA, 32'h0);
      drain();
      tick();
      cp0.CP0_WE = 1'b0;
      expect_val("mtc0_status", SEL_STATUS, 32'h0000FC01);
      expect_val("int_before", SEL_INT, 32'h0);
      drain();
      IntReq = 6'b000100;
      PCWrite = 1'b1;
      PC_D = 32'h208;
      tick();
      expect_val("int_edge1", SEL_INT, 32'h0);
      drain();
      tick();
      expect_val("int_edge2", SEL_INT, 32'h1);
      expect_val("int_cause", SEL_CAUSE, 32'h1020);
      expect_val("int_pc", SEL_PC, 32'h208);
      drain();
      ExcEnter = 1'b1;
      ExcCode = 5'd0;
      PC_D = 32'h180;
      tick();
      ExcEnter = 1'b0;
      PCWrite = 1'b0;
      expect_val("irq_epc", SEL_EPC, 32'h208);
      expect_val("irq_intpend", SEL_INT, 32'h0);
      expect_val("irq_status", SEL_STATUS, 32'h0000FC03);
      expect_val("irq_cause", SEL_CAUSE, 32'h1000);
      drain();
      ERET = 1'b1;
      tick();
      ERET = 1'b0;
      expect_val("eret_intpend", SEL_INT, 32'h1);
      expect_val("eret_status2", SEL_STATUS, 32'h0000FC01);
      drain();

      // priority: ExcEnter beats MTC0 Status
      ExcEnter = 1'b1;
      ExcCode = 5'd12;
      mtc0(5'd12, 32'h0);
      tick();
      ExcEnter = 1'b0;
      expect_val("prio_status", SEL_STATUS, 32'h0000FC03);
      expect_val("prio_epc", SEL_EPC, 32'h17C);
      expect_val("prio_cause", SEL_CAUSE, 32'h1030);
      drain();
      // ERET beats MTC0 EPC
      ERET = 1'b1;
      mtc0(5'd14, 32'hDEADBEEF);
      tick();
      ERET = 1'b0;
      expect_val("prio_eret_epc", SEL_EPC, 32'h17C);
      expect_val("prio_eret_st", SEL_STATUS, 32'h0000FC01);
      drain();

      // write masking and read mux
      mtc0(5'd14, 32'hFFFFFFFF);
      tick();
      cp0.CP0_WE = 1'b0;
      expect_val("epc_mask", SEL_RDATA, 32'hFFFFFFFC);
      drain();
      mtc0(5'd13, 32'hFFFFFFFF);
      tick();
      cp0.CP0_WE = 1'b0;
      expect_val("cause_ro", SEL_CAUSE, 32'h1030);
      expect_val("rd_cause", SEL_RDATA, 32'h1030);
      drain();
      cp0.CP0_Addr = 5'd15;
      expect_val("rd_prid", SEL_RDATA, C_PRID);
      drain();
      cp0.CP0_Addr = 5'd3;
      expect_val("rd_other", SEL_RDATA, 32'h0);
      drain();
      cp0.CP0_Addr = 5'd12;
      expect_val("rd_status", SEL_RDATA, 32'h0000FC01);
      drain();

      // IntReq deassert has two-edge latency
      IntReq = 6'd0;
      tick();
      expect_val("deassert_e1", SEL_INT, 32'h1);
      drain();
      tick();
      expect_val("deassert_e2", SEL_INT, 32'h0);
      expect_val("deassert_cause", SEL_CAUSE, 32'h30);
      drain();

      // reset mid-exception clears at once
      ExcEnter = 1'b1;
      ExcCode = 5'd10;
      tick();
      ExcEnter = 1'b0;
      rst_n = 1'b0;
      expect_val("midrst_status", SEL_STATUS, 32'h0);
      expect_val("midrst_cause", SEL_CAUSE, 32'h0);
      expect_val("midrst_pc", SEL_PC, 32'h0);
      expect_val("midrst_epc", SEL_EPC, 32'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
`default_nettype wire
